// File: rtl/addsub_seq_if.sv
// Request/result bundle for the multi-precision add/subtract sequencer.
// With ADDSUB_SEQ_ZERO_FLAG_EN defined, the bundle also carries a zero flag.
interface addsub_seq_if #(parameter int NSLICE = 4);
   localparam int W = 4 * NSLICE;

   logic         in_valid;
   logic         in_ready;
   logic [W-1:0] op_a;
   logic [W-1:0] op_b;
   logic         sub;
   logic         res_valid;
   logic         res_ready;
   logic [W-1:0] result;
   logic         carry_out;
   logic         overflow;
   logic         busy;

`ifdef ADDSUB_SEQ_ZERO_FLAG_EN
   logic         zero;

   modport master (
      output in_valid, op_a, op_b, sub, res_ready,
      input  in_ready, res_valid, result, carry_out, overflow, busy, zero
   );

   modport slave (
      input  in_valid, op_a, op_b, sub, res_ready,
      output in_ready, res_valid, result, carry_out, overflow, busy, zero
   );
`else
   modport master (
      output in_valid, op_a, op_b, sub, res_ready,
      input  in_ready, res_valid, result, carry_out, overflow, busy
   );

   modport slave (
      input  in_valid, op_a, op_b, sub, res_ready,
      output in_ready, res_valid, result, carry_out, overflow, busy
   );
`endif
endinterface

// File: rtl/addsub_seq_ctrl.sv
// Multi-precision add/subtract sequencer: one 4-bit slice per cycle across a
// 4*NSLICE-bit operand pair, with the inter-slice carry held in a register.
// Optional feature macro: ADDSUB_SEQ_ZERO_FLAG_EN adds a registered zero flag.
module addsub_seq_ctrl #(
   parameter int NSLICE = 4
) (
   input logic         clk,
   input logic         rst_n,
   addsub_seq_if.slave bus
);
   localparam int W     = 4 * NSLICE;
   localparam int IDX_W = (NSLICE > 1) ? $clog2(NSLICE) : 1;
   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NSLICE - 1);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;

   state_t           state_q, state_d;
   logic [W-1:0]     a_q, b_q, result_q;
   logic             sub_q, carry_q, cout_q, ovf_q;
   logic [IDX_W-1:0] idx_q;
   logic             accept, last_slice;
   logic [3:0]       slice_a, slice_b, slice_sum;
   logic             slice_c3, slice_c4;

   // Four chained full-adder cells; returns {c4, c3, sum}.
   function automatic logic [5:0] slice_add(input logic [3:0] a,
                                            input logic [3:0] b,
                                            input logic       cin);
      logic [4:0] c;
      logic [3:0] s;
      c[0] = cin;
      for (int i = 0; i < 4; i++) begin
         s[i]   = a[i] ^ b[i] ^ c[i];
         c[i+1] = (a[i] & b[i]) | (c[i] & (a[i] ^ b[i]));
      end
      return {c[4], c[3], s};
   endfunction

   // Select the active slice and run it through the 4-bit adder.
   always_comb begin
      slice_a = a_q[4*int'(idx_q) +: 4];
      slice_b = b_q[4*int'(idx_q) +: 4] ^ {4{sub_q}};
      {slice_c4, slice_c3, slice_sum} = slice_add(slice_a, slice_b, carry_q);
   end

   // State register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state_q <= IDLE;
      else        state_q <= state_d;
   end

   // Next-state logic and handshake decode.
   always_comb begin
      state_d    = state_q;
      accept     = 1'b0;
      last_slice = 1'b0;
      case (state_q)
         IDLE: begin
            if (bus.in_valid) begin
               accept  = 1'b1;
               state_d = RUN;
            end
         end
         RUN: begin
            if (idx_q == LAST_IDX) begin
               last_slice = 1'b1;
               state_d    = DONE;
            end
         end
         DONE: begin
            if (bus.res_ready) state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   // Operand capture, slice sequencing and flag generation.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         a_q      <= '0;
         b_q      <= '0;
         sub_q    <= 1'b0;
         idx_q    <= '0;
         carry_q  <= 1'b0;
         result_q <= '0;
         cout_q   <= 1'b0;
         ovf_q    <= 1'b0;
      end else if (accept) begin
         a_q     <= bus.op_a;
         b_q     <= bus.op_b;
         sub_q   <= bus.sub;
         idx_q   <= '0;
         carry_q <= bus.sub;
      end else if (state_q == RUN) begin
         result_q[4*int'(idx_q) +: 4] <= slice_sum;
         carry_q <= slice_c4;
         idx_q   <= idx_q + 1'b1;
         if (last_slice) begin
            cout_q <= slice_c4;
            ovf_q  <= slice_c3 ^ slice_c4;
         end
      end
   end

`ifdef ADDSUB_SEQ_ZERO_FLAG_EN
   logic zero_acc_q, zero_q;

   // AND of per-slice zero bits, published together with the last slice.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         zero_acc_q <= 1'b0;
         zero_q     <= 1'b0;
      end else if (accept) begin
         zero_acc_q <= 1'b1;
      end else if (state_q == RUN) begin
         zero_acc_q <= zero_acc_q & (slice_sum == 4'd0);
         if (last_slice) zero_q <= zero_acc_q & (slice_sum == 4'd0);
      end
   end

   assign bus.zero = zero_q;
`endif

   assign bus.in_ready  = (state_q == IDLE);
   assign bus.res_valid = (state_q == DONE);
   assign bus.busy      = (state_q == RUN) || (state_q == DONE);
   assign bus.result    = result_q;
   assign bus.carry_out = cout_q;
   assign bus.overflow  = ovf_q;
endmodule
